// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer code conversions, used by both the
// write-side and read-side flag generators.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Callers zero-extend narrower pointers; leading zeros decode to zeros.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this domain.
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/wr_full_gen.sv
// Write-side flag generator: Gray write pointer export, full, occupancy,
// almost-full and sticky overflow, against a synchronized read pointer.
module wr_full_gen
  import fifo_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wr_clk,
  input  logic                rst_n,
  input  logic [ADDR_WIDTH:0] wr_ptr_ext,
  input  logic                wr_en_sys,
  input  logic [ADDR_WIDTH:0] rd_ptr_gray,
  output logic [ADDR_WIDTH:0] wr_ptr_gray,
  output logic                full,
  output logic                almost_full,
  output logic [ADDR_WIDTH:0] wr_level,
  output logic                overflow_err
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [31:0]           w_wr_gray32;
  logic [31:0]           w_rd_bin32;
  logic [ADDR_WIDTH:0]   w_wr_gray;
  logic [ADDR_WIDTH:0]   w_rd_gray_sync;
  logic [ADDR_WIDTH:0]   w_rd_bin_sync;
  logic [ADDR_WIDTH:0]   w_full_cmp;
  logic [ADDR_WIDTH:0]   r_wr_gray;
  logic                  r_afull;
  logic                  r_ovf;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .i_clk   (wr_clk),
    .i_rst_n (rst_n),
    .i_d     (rd_ptr_gray),
    .o_q     (w_rd_gray_sync)
  );

  assign w_wr_gray32   = bin2gray(32'(wr_ptr_ext));
  assign w_wr_gray     = w_wr_gray32[ADDR_WIDTH:0];
  assign w_rd_bin32    = gray2bin(32'(w_rd_gray_sync));
  assign w_rd_bin_sync = w_rd_bin32[ADDR_WIDTH:0];

  // Full when write is exactly one lap ahead: in Gray that is the top two
  // bits inverted, the rest equal.
  assign w_full_cmp = {~w_rd_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                       w_rd_gray_sync[ADDR_WIDTH-2:0]};
  assign full       = (w_wr_gray == w_full_cmp);
  assign wr_level   = wr_ptr_ext - w_rd_bin_sync;

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      r_wr_gray <= '0;
      r_afull   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_gray <= w_wr_gray;
      r_afull   <= (wr_level >= PW'(AFULL_THRESH));
      if (full && wr_en_sys) r_ovf <= 1'b1;
    end
  end

  assign wr_ptr_gray  = r_wr_gray;
  assign almost_full  = r_afull;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_wr_full_gen.sv
// Directed checks of the write-side flag generator at DEPTH=16, 2 sync stages.
module tb_wr_full_gen;

  logic       wr_clk = 1'b0;
  logic       rst_n;
  logic [4:0] wr_ptr_ext;
  logic       wr_en_sys;
  logic [4:0] rd_ptr_gray;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow_err;

  int n_chk = 0;
  int n_err = 0;

  wr_full_gen #(
    .DEPTH(16), .ADDR_WIDTH(4), .SYNC_STAGES(2), .AFULL_THRESH(12)
  ) dut (
    .wr_clk       (wr_clk),
    .rst_n        (rst_n),
    .wr_ptr_ext   (wr_ptr_ext),
    .wr_en_sys    (wr_en_sys),
    .rd_ptr_gray  (rd_ptr_gray),
    .wr_ptr_gray  (wr_ptr_gray),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow_err (overflow_err)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_ptr_ext = '0; wr_en_sys = 1'b0; rd_ptr_gray = '0;
    repeat (3) step();
    chk("rst_gray",  32'(wr_ptr_gray),  32'd0);
    chk("rst_full",  32'(full),         32'd0);
    chk("rst_afull", 32'(almost_full),  32'd0);
    chk("rst_level", 32'(wr_level),     32'd0);
    chk("rst_ovf",   32'(overflow_err), 32'd0);

    rst_n = 1'b1;
    step();
    for (int i = 0; i <= 16; i++) begin
      wr_ptr_ext = 5'(i);
      #1;
      chk($sformatf("lvl%0d", i),  32'(wr_level), 32'(i));
      chk($sformatf("full%0d", i), 32'(full),     (i == 16) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("gray%0d", i),  32'(wr_ptr_gray), 32'(i ^ (i >> 1)));
      chk($sformatf("afull%0d", i), 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
    end
    wr_ptr_ext = 5'd7;
    step();
    chk("gray7", 32'(wr_ptr_gray), 32'b00100);

    // Full, overflow pulse.
    wr_ptr_ext = 5'd16;
    #1;
    chk("full16", 32'(full), 32'd1);
    wr_en_sys = 1'b1;
    step();
    wr_en_sys = 1'b0;
    chk("ovf_set", 32'(overflow_err), 32'd1);

    // Read advance reaches full/level after exactly 2 cycles.
    rd_ptr_gray = 5'b00001;
    #1;
    chk("rd_lag0", 32'(full), 32'd1);
    step();
    chk("rd_lag1", 32'(full), 32'd1);
    step();
    chk("rd_lag2_full", 32'(full),     32'd0);
    chk("rd_lag2_lvl",  32'(wr_level), 32'd15);
    chk("ovf_hold",     32'(overflow_err), 32'd1);

    // Wrap: write at 0 after wrapping, read at binary 16.
    wr_ptr_ext = 5'd0; rd_ptr_gray = 5'b11000;
    step(); step();
    chk("wrap_full", 32'(full),     32'd1);
    chk("wrap_lvl",  32'(wr_level), 32'd16);

    // Write at 31, read at 15: full across the pointer wrap.
    wr_ptr_ext = 5'd31; rd_ptr_gray = 5'b01000;
    step(); step();
    chk("w31_full", 32'(full),     32'd1);
    chk("w31_lvl",  32'(wr_level), 32'd16);

    // Write and synchronized read both advance by one: level unchanged.
    wr_ptr_ext = 5'd5; rd_ptr_gray = 5'b00011;
    step(); step();
    chk("sim_lvl0", 32'(wr_level), 32'd3);
    rd_ptr_gray = 5'b00010;
    step();
    wr_ptr_ext = 5'd6;
    step();
    chk("sim_lvl1", 32'(wr_level), 32'd3);
    chk("sim_full", 32'(full),     32'd0);

    // Mid-operation reset; synchronizer refills afterwards.
    rst_n = 1'b0; wr_ptr_ext = 5'd0;
    step();
    chk("mrst_ovf",   32'(overflow_err), 32'd0);
    chk("mrst_gray",  32'(wr_ptr_gray),  32'd0);
    chk("mrst_afull", 32'(almost_full),  32'd0);
    chk("mrst_lvl",   32'(wr_level),     32'd0);
    rst_n = 1'b1;
    step();
    chk("refill1", 32'(wr_level), 32'd0);
    step();
    chk("refill2", 32'(wr_level), 32'd29);
    chk("refill2_ovf", 32'(overflow_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
